// File: rtl/muldiv_seq_ctrl_pkg.sv
// Op codes, state encodings and decode helpers for the HI/LO sequencing controller.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package muldiv_seq_ctrl_pkg;

    // HI/LO-class op codes; 7 (MFHI) and anything unknown behave as OP_NONE here
    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_MFHI  = 3'd7;

    // Sequencer state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    // Ops that occupy the iterative datapath and stall the PC
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter_cnt.sv
// Loadable down-counter tracking the remaining datapath iterations.
// Latency: load/clear/decrement take effect on the next clock; zero flag is combinational.
// Backpressure: none; decrement saturates at zero.
module muldiv_iter_cnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    // Clear wins over load, load wins over decrement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Last iteration indicator
    always_comb begin
        zero = (cnt == '0);
    end

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Sequencer for the iterative mul/div datapath and HI/LO register enables; stalls the PC during long ops.
// Latency: long op holds the PC for N+1 cycles and writes HI/LO on the following cycle; MTHI/MTLO write same cycle.
// Backpressure: the core is stalled via pc_e=0; flush aborts any operation without a HI/LO write.
module muldiv_seq_ctrl
    import muldiv_seq_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 32,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    input  logic [2:0] op,
    input  logic       dz,
    input  logic       flush,
    output logic       pc_e,
    output logic       dp_start,
    output logic       dp_step,
    output logic       dp_signed,
    output logic       dp_div,
    output logic       hi_e,
    output logic       lo_e,
    output logic       hilo_src,
    output logic       busy
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             skip_q;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             start;
    logic             start_skip;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_load_val;
    logic             in_idle;
    logic             mthi;
    logic             mtlo;

    // Decode of the incoming instruction; a start is only taken from IDLE and never on a flush
    always_comb begin
        in_idle      = (state == ST_IDLE);
        start        = in_idle && op_valid && is_long_op(op) && !flush;
        start_skip   = start && is_div_op(op) && dz;
        cnt_load     = start && !start_skip;
        cnt_load_val = is_div_op(op) ? DIV_LOAD : MUL_LOAD;
        cnt_dec      = (state == ST_RUN) && !flush && !cnt_zero;
        mthi         = in_idle && op_valid && (op == OP_MTHI);
        mtlo         = in_idle && op_valid && (op == OP_MTLO);
    end

    muldiv_iter_cnt #(
        .W(CNT_W)
    ) u_iter_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // Next-state logic; flush always returns to IDLE, divide-by-zero bypasses RUN
    always_comb begin
        state_nxt = ST_IDLE;
        if (!flush) begin
            case (state)
                ST_IDLE: begin
                    if (start_skip) begin
                        state_nxt = ST_WB;
                    end else if (start) begin
                        state_nxt = ST_RUN;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_RUN:  state_nxt = cnt_zero ? ST_WB : ST_RUN;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, skip marker and latched operation flavour
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            skip_q    <= 1'b0;
            dp_signed <= 1'b0;
            dp_div    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (flush || (state == ST_WB)) begin
                skip_q <= 1'b0;
            end else if (start) begin
                skip_q <= start_skip;
            end
            if (start) begin
                dp_signed <= is_signed_op(op);
                dp_div    <= is_div_op(op);
            end
        end
    end

    // Output decode; Mealy in IDLE so MTHI/MTLO and long-op starts act in the issuing cycle
    always_comb begin
        busy     = !in_idle;
        dp_start = start;
        dp_step  = (state == ST_RUN) && !flush;
        hilo_src = mthi || mtlo;
        hi_e     = !flush && (mthi || ((state == ST_WB) && !skip_q));
        lo_e     = !flush && (mtlo || ((state == ST_WB) && !skip_q));
        if (flush) begin
            pc_e = 1'b1;
        end else begin
            case (state)
                ST_IDLE: pc_e = !start;
                ST_RUN:  pc_e = 1'b0;
                default: pc_e = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed bench for muldiv_seq_ctrl: stimulus pushes per-cycle expected outputs, a monitor compares.
module tb_muldiv_seq_ctrl;
    import muldiv_seq_ctrl_pkg::*;

    localparam int MUL_N = 32;
    localparam int DIV_N = 33;

    typedef struct packed {
        logic pc_e;
        logic dp_start;
        logic dp_step;
        logic dp_signed;
        logic dp_div;
        logic hi_e;
        logic lo_e;
        logic hilo_src;
        logic busy;
    } outv_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       op_valid = 1'b0;
    logic [2:0] op = 3'd0;
    logic       dz = 1'b0;
    logic       flush = 1'b0;
    logic       pc_e, dp_start, dp_step, dp_signed, dp_div, hi_e, lo_e, hilo_src, busy;

    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    logic  exp_signed = 1'b0;
    logic  exp_div = 1'b0;
    outv_t exp_q[$];

    muldiv_seq_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .dz(dz), .flush(flush),
        .pc_e(pc_e), .dp_start(dp_start), .dp_step(dp_step), .dp_signed(dp_signed),
        .dp_div(dp_div), .hi_e(hi_e), .lo_e(lo_e), .hilo_src(hilo_src), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic outv_t sample();
        return '{pc_e, dp_start, dp_step, dp_signed, dp_div, hi_e, lo_e, hilo_src, busy};
    endfunction

    function automatic outv_t mk(input logic pc, input logic st, input logic sp,
                                 input logic hi, input logic lo, input logic src, input logic bz);
        return '{pc, st, sp, exp_signed, exp_div, hi, lo, src, bz};
    endfunction

    task automatic check(input string name, input outv_t got, input outv_t want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s @cyc%0d got %b want %b (pc_e,start,step,sgn,div,hi,lo,src,busy)",
                     name, cyc, got, want);
        end
    endtask

    // Monitor: every cycle with an outstanding expectation is compared at the falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) check("cycle", sample(), exp_q.pop_front());
    end

    task automatic drive(input logic v, input logic [2:0] o, input logic z, input logic f, input outv_t e);
        @(posedge clk);
        #1;
        op_valid = v;
        op       = o;
        dz       = z;
        flush    = f;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic v, input logic [2:0] o);
        logic is_hi, is_lo;
        is_hi = v && (o == OP_MTHI);
        is_lo = v && (o == OP_MTLO);
        drive(v, o, 1'b0, 1'b0, mk(1, 0, 0, is_hi, is_lo, is_hi || is_lo, 0));
    endtask

    // Long op issued at T; flush_at = k flushes on T+k (0 disables)
    task automatic long_op(input logic [2:0] o, input logic z, input int flush_at);
        int   n;
        logic isdiv;
        isdiv = (o == OP_DIV) || (o == OP_DIVU);
        n = isdiv ? DIV_N : MUL_N;
        drive(1'b1, o, z, 1'b0, mk(0, 1, 0, 0, 0, 0, 0));
        exp_signed = (o == OP_MULT) || (o == OP_DIV);
        exp_div    = isdiv;
        if (isdiv && z) begin
            drive(1'b0, OP_NONE, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0, 1));
            return;
        end
        for (int i = 1; i <= n; i++) begin
            if (i == flush_at) begin
                drive(1'b1, OP_MTHI, 1'b1, 1'b1, mk(1, 0, 0, 0, 0, 0, 1));
                return;
            end
            // Ops presented during RUN must be ignored
            drive(1'b1, OP_MTLO, 1'b1, 1'b0, mk(0, 0, 1, 0, 0, 0, 1));
        end
        if (flush_at == n + 1)
            drive(1'b0, OP_NONE, 1'b0, 1'b1, mk(1, 0, 0, 0, 0, 0, 1));
        else
            drive(1'b0, OP_NONE, 1'b0, 1'b0, mk(1, 0, 0, 1, 1, 0, 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", sample(), mk(1, 0, 0, 0, 0, 0, 0));
        #1;
        rst = 1'b0;

        // IDLE decode of short ops
        idle(1'b0, OP_NONE);
        idle(1'b1, OP_MTHI);
        idle(1'b1, OP_MTLO);
        idle(1'b1, OP_MFHI);
        idle(1'b0, OP_MULT);
        idle(1'b1, OP_NONE);

        // Full MULT, then divide-by-zero DIVU
        long_op(OP_MULT, 1'b0, 0);
        idle(1'b0, OP_NONE);
        long_op(OP_DIVU, 1'b1, 0);
        idle(1'b0, OP_NONE);

        // DIV flushed on T+5
        long_op(OP_DIV, 1'b0, 5);
        idle(1'b0, OP_NONE);

        // Flush in IDLE blocks a start
        drive(1'b1, OP_MULTU, 1'b0, 1'b1, mk(1, 0, 0, 0, 0, 0, 0));
        idle(1'b0, OP_NONE);

        // Back-to-back MULT then DIV, then a MTHI right after WB
        long_op(OP_MULT, 1'b0, 0);
        long_op(OP_DIV, 1'b0, 0);
        idle(1'b1, OP_MTHI);

        // DIVU flushed in its WB cycle: no write
        long_op(OP_DIVU, 1'b0, DIV_N + 1);
        idle(1'b0, OP_NONE);

        // MULTU aborted by an asynchronous reset on T+10
        drive(1'b1, OP_MULTU, 1'b0, 1'b0, mk(0, 1, 0, 0, 0, 0, 0));
        exp_signed = 1'b0;
        exp_div    = 1'b0;
        for (int i = 1; i <= 9; i++) drive(1'b0, OP_NONE, 1'b0, 1'b0, mk(0, 0, 1, 0, 0, 0, 1));
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        check("run_before_rst", sample(), mk(0, 0, 1, 0, 0, 0, 1));
        #1;
        rst = 1'b1;
        #1;
        check("async_rst", sample(), mk(1, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check("rst_held", sample(), mk(1, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        long_op(OP_MULT, 1'b0, 0);
        idle(1'b0, OP_NONE);
        idle(1'b1, OP_MTLO);

        repeat (3) @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_seq_ctrl.md
Name: muldiv_seq_ctrl

Overview:
Sequencing controller for the iterative multiply/divide unit and the HI/LO dff32 registers in the 54-instruction MIPS CPU. It decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO, pulses start and step enables to the datapath, and drives the HI/LO register enables (e). While a long operation runs, it deasserts the PC register enable, so the single-cycle core stalls until the result is written back.

Parameters:
MUL_CYCLES, 32, number of dp_step cycles for MULT/MULTU (>=1)
DIV_CYCLES, 33, number of dp_step cycles for DIV/DIVU (>=1)
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
op_valid  input  1  current instruction is a HI/LO-class op
op  input  3  op code, encoding from muldiv_defs.vh
dz  input  1  divisor == 0; sampled only at DIV/DIVU start
flush  input  1  exception/eret kill; synchronous, highest priority after rst
pc_e  output  1  enable for the PC dff32; 0 = hold
dp_start  output  1  one-cycle pulse that loads the datapath operands
dp_step  output  1  per-iteration enable to the datapath
dp_signed  output  1  registered; 1 for MULT/DIV
dp_div  output  1  registered; 1 for DIV/DIVU
hi_e  output  1  HI dff32 enable
lo_e  output  1  LO dff32 enable
hilo_src  output  1  HI/LO d-mux select: 0 = datapath result, 1 = rs
busy  output  1  state != IDLE

Behaviour:
- States: IDLE, RUN, WB. Registers: state, cnt[CNT_W-1:0], dp_signed, dp_div, skip_q.
- rst=1 (asynchronous): state=IDLE, cnt=0, dp_signed=0, dp_div=0, skip_q=0.
  - Resulting outputs: pc_e=1; dp_start=dp_step=hi_e=lo_e=hilo_src=busy=0.
  - Reset mid-RUN abandons the operation with no HI/LO write.
- All other outputs are combinational from state and inputs (Mealy in IDLE).
- IDLE, op_valid, op in {MULT,MULTU,DIV,DIVU}, flush=0 (cycle T):
  - Outputs at T: dp_start=1, pc_e=0.
  - Latches dp_signed and dp_div.
  - DIV/DIVU with dz=1: skip_q<=1, next state WB (no RUN cycles).
  - Otherwise: cnt<=N-1, where N = MUL_CYCLES or DIV_CYCLES; next state RUN.
- RUN: dp_step=1, pc_e=0. If cnt==0, go to WB; else cnt<=cnt-1. Exactly N RUN cycles. op_valid and op are ignored.
- WB: pc_e=1 (the stalled instruction retires); hilo_src=0.
  - hi_e=lo_e = ~skip_q.
  - Next state IDLE; skip_q<=0.
- Long-op timing: PC is held for N+1 cycles (T..T+N). The write and PC advance occur at T+N+1. With dz: PC held at T only; WB at T+1 with no write.
- IDLE, MTHI: hi_e=1, hilo_src=1, pc_e=1; no state change. MTLO is the same with lo_e.
- IDLE, MFHI/MFLO, OP_NONE, or op_valid=0: pc_e=1, all other outputs 0.
- Back-to-back: the next instruction is seen in IDLE on the cycle after WB, so a second long op starts at T+N+2. No hazard logic is needed beyond the stall.
- flush=1 in any state:
  - Suppresses dp_start, dp_step, hi_e and lo_e that cycle; forces pc_e=1.
  - Next state IDLE; cnt=0; skip_q=0.
  - Flush in IDLE together with a long op prevents the start.
- Undefined op codes (7) are treated as OP_NONE.

Decomposition:
- muldiv_defs.vh holds op codes (OP_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7 treated as NONE here) and state encodings (IDLE=0, RUN=1, WB=2).
- One sub-module, muldiv_iter_cnt: loadable down-counter with load, dec, zero flag and async rst.
- FSM and output decode stay in muldiv_seq_ctrl.

Test Plan:
- MULT at T (op_valid=1, op=1) -> dp_start=1 at T; dp_step=1 on T+1..T+32; pc_e=0 on T..T+32; at T+33 hi_e=lo_e=1, hilo_src=0, pc_e=1; dp_signed=1, dp_div=0.
- DIVU with dz=1 at T -> pc_e=0 at T; at T+1 state WB, hi_e=lo_e=0, pc_e=1; dp_step never asserted; busy=0 at T+2.
- MTHI in IDLE -> same cycle hi_e=1, lo_e=0, hilo_src=1, pc_e=1; busy stays 0.
- DIV started at T, flush=1 at T+5 -> dp_step=0 and pc_e=1 at T+5; IDLE at T+6; hi_e and lo_e never pulse.
- rst=1 asynchronously at T+10 of a MULTU -> busy=0 and pc_e=1 immediately without a clock edge; after release, a fresh MULT completes normally in 34 cycles.
- MULT immediately followed by DIV -> DIV dp_start at T+34 with dp_signed=1, dp_div=1; its WB at T+34+34 with hi_e=lo_e=1.
